// File: rtl/mips_stage_reg_fetch_rx.sv
// Fetch->register receiver: 2-entry skid queue, branch/jump resolution at issue, wrong-path squash.
// Optional MIPS_STAGE_REG_FETCH_RX_STATS_EN adds saturating redirect/taken/squash counters.
module mips_stage_reg_fetch_rx #(
  parameter int unsigned DELAYED  = 1,
  parameter int unsigned SQUASH_N = 1,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic [31:0] pc_instr,
  input  logic [31:0] pc_addr,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_addr,
  output logic        redir_valid,
  output logic [1:0]  redir_kind,
  output logic [31:0] redir_port1,
  output logic        redir_eq
`ifdef MIPS_STAGE_REG_FETCH_RX_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_squashed
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 2;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BR   = 2'd1;
  localparam logic [1:0] KIND_JI   = 2'd2;
  localparam logic [1:0] KIND_JR   = 2'd3;

  typedef enum logic [1:0] {RUN, SLOT, SQUASH} state_t;

  if (DEPTH != 2) begin : g_depth_check
    $error("mips_stage_reg_fetch_rx: DEPTH must be 2");
  end
  if (SQUASH_N > 3) begin : g_squash_check
    $error("mips_stage_reg_fetch_rx: SQUASH_N must be 0..3");
  end

  logic [XLEN-1:0]  q_instr [DEPTH];
  logic [XLEN-1:0]  q_addr  [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [OCC_W-1:0] count;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       full, empty, push, pop, drop, deq;
  logic [5:0] op, funct;
  logic [1:0] kind_c;
  logic       eq_c, taken_c, fire;

  assign full      = (count == OCC_W'(DEPTH));
  assign empty     = (count == '0);
  assign dec_valid = !empty && (state_q != SQUASH);
  assign pop       = dec_valid && dec_ready;
  assign drop      = (state_q == SQUASH) && !empty;
  assign deq       = pop || drop;
  assign pc_ready  = !full || pop;
  assign push      = pc_valid && pc_ready;

  assign dec_instr  = q_instr[rd_ptr];
  assign dec_addr   = q_addr[rd_ptr];
  assign rf_rs_addr = dec_instr[25:21];
  assign rf_rt_addr = dec_instr[20:16];
  assign op         = dec_instr[31:26];
  assign funct      = dec_instr[5:0];

  // Skid queue storage; a full-queue push+pop overwrites the slot being popped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_addr[i]  <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= pc_instr;
        q_addr[wr_ptr]  <= pc_addr;
        wr_ptr          <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + OCC_W'(push) - OCC_W'(deq);
    end
  end

  // Control-transfer decode of the queue head.
  always_comb begin
    kind_c = KIND_NONE;
    eq_c   = 1'b0;
    unique case (op)
      OP_BEQ:     begin kind_c = KIND_BR; eq_c = (rf_rs_data == rf_rt_data); end
      OP_BNE:     begin kind_c = KIND_BR; eq_c = (rf_rs_data != rf_rt_data); end
      OP_J,
      OP_JAL:     kind_c = KIND_JI;
      OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) kind_c = KIND_JR;
      default:    kind_c = KIND_NONE;
    endcase
  end

  assign taken_c = (kind_c == KIND_JI) || (kind_c == KIND_JR) || (kind_c == KIND_BR && eq_c);
  assign fire    = pop && (state_q == RUN) && (kind_c != KIND_NONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redir_valid <= 1'b0;
      redir_kind  <= KIND_NONE;
      redir_port1 <= '0;
      redir_eq    <= 1'b0;
    end else begin
      redir_valid <= fire;
      redir_kind  <= fire ? kind_c : KIND_NONE;
      redir_eq    <= fire && eq_c;
      redir_port1 <= (fire && kind_c == KIND_JR) ? rf_rs_data : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delay slot issues unredirected; SQUASH drops one head per non-empty cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (fire && taken_c) begin
          if (DELAYED != 0) begin
            state_d = SLOT;
          end else if (SQUASH_N != 0) begin
            state_d = SQUASH;
            cnt_d   = CNT_W'(SQUASH_N);
          end
        end
      end
      SLOT: begin
        if (pop) begin
          if (SQUASH_N != 0) begin
            state_d = SQUASH;
            cnt_d   = CNT_W'(SQUASH_N);
          end else begin
            state_d = RUN;
          end
        end
      end
      SQUASH: begin
        if (drop) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef MIPS_STAGE_REG_FETCH_RX_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_squashed <= '0;
    end else begin
      if (fire && stat_branches != '1)            stat_branches <= stat_branches + XLEN'(1);
      if (fire && taken_c && stat_taken != '1)    stat_taken    <= stat_taken + XLEN'(1);
      if (drop && stat_squashed != '1)            stat_squashed <= stat_squashed + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mips_stage_reg_fetch_rx.sv
// Bench for mips_stage_reg_fetch_rx: two instances (DELAYED=1/SQUASH_N=1 and DELAYED=0/SQUASH_N=2)
// fed the same fetch stream, compared against a sequence-level issue/redirect model.
module tb_mips_stage_reg_fetch_rx;
  localparam int MAXN = 256;
  localparam int D0 = 1, N0 = 1, D1 = 0, N1 = 2;

  typedef struct packed { logic [31:0] instr; logic [31:0] addr; } ent_t;
  typedef struct packed { logic [31:0] tag; logic [1:0] kind; logic eq; logic [31:0] port1; } red_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pc_valid [2];
  logic        pc_ready [2];
  logic [31:0] pc_instr [2];
  logic [31:0] pc_addr [2];
  logic [4:0]  rf_rs_addr [2];
  logic [4:0]  rf_rt_addr [2];
  logic [31:0] rf_rs_data [2];
  logic [31:0] rf_rt_data [2];
  logic        dec_valid [2];
  logic        dec_ready;
  logic [31:0] dec_instr [2];
  logic [31:0] dec_addr [2];
  logic        redir_valid [2];
  logic [1:0]  redir_kind [2];
  logic [31:0] redir_port1 [2];
  logic        redir_eq [2];
  logic [31:0] regs [32];
`ifdef MIPS_STAGE_REG_FETCH_RX_STATS_EN
  logic [31:0] st_b [2], st_t [2], st_s [2];
`endif

  always #5 clock = ~clock;

  assign rf_rs_data[0] = regs[rf_rs_addr[0]];
  assign rf_rt_data[0] = regs[rf_rt_addr[0]];
  assign rf_rs_data[1] = regs[rf_rs_addr[1]];
  assign rf_rt_data[1] = regs[rf_rt_addr[1]];

  mips_stage_reg_fetch_rx #(.DELAYED(D0), .SQUASH_N(N0), .DEPTH(2)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .pc_valid(pc_valid[0]), .pc_ready(pc_ready[0]), .pc_instr(pc_instr[0]), .pc_addr(pc_addr[0]),
    .rf_rs_addr(rf_rs_addr[0]), .rf_rt_addr(rf_rt_addr[0]),
    .rf_rs_data(rf_rs_data[0]), .rf_rt_data(rf_rt_data[0]),
    .dec_valid(dec_valid[0]), .dec_ready(dec_ready), .dec_instr(dec_instr[0]), .dec_addr(dec_addr[0]),
    .redir_valid(redir_valid[0]), .redir_kind(redir_kind[0]), .redir_port1(redir_port1[0]),
    .redir_eq(redir_eq[0])
`ifdef MIPS_STAGE_REG_FETCH_RX_STATS_EN
    , .stat_branches(st_b[0]), .stat_taken(st_t[0]), .stat_squashed(st_s[0])
`endif
  );

  mips_stage_reg_fetch_rx #(.DELAYED(D1), .SQUASH_N(N1), .DEPTH(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .pc_valid(pc_valid[1]), .pc_ready(pc_ready[1]), .pc_instr(pc_instr[1]), .pc_addr(pc_addr[1]),
    .rf_rs_addr(rf_rs_addr[1]), .rf_rt_addr(rf_rt_addr[1]),
    .rf_rs_data(rf_rs_data[1]), .rf_rt_data(rf_rt_data[1]),
    .dec_valid(dec_valid[1]), .dec_ready(dec_ready), .dec_instr(dec_instr[1]), .dec_addr(dec_addr[1]),
    .redir_valid(redir_valid[1]), .redir_kind(redir_kind[1]), .redir_port1(redir_port1[1]),
    .redir_eq(redir_eq[1])
`ifdef MIPS_STAGE_REG_FETCH_RX_STATS_EN
    , .stat_branches(st_b[1]), .stat_taken(st_t[1]), .stat_squashed(st_s[1])
`endif
  );

  int   vectors = 0, miscompares = 0, cycle_no = 0;
  ent_t seq [MAXN];
  int   seq_len, push_idx [2];
  int   valid_pct = 100, rdy_pct = 100, rdy_force = 1;
  ent_t obs_iss [2][MAXN];
  int   obs_cyc [2][MAXN];
  int   iss_n [2];
  red_t obs_red [2][MAXN];
  int   red_n [2];
  ent_t exp_iss [2][MAXN];
  int   exp_iss_n [2];
  red_t exp_red [2][MAXN];
  int   exp_red_n [2];
  bit   prev_pop [2], acc [2];
  logic [31:0] prev_addr [2];

  // Offer pending stream entries and set the shared dec_ready for the coming edge.
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (push_idx[k] < seq_len && int'($urandom_range(0, 99)) < valid_pct) begin
        pc_valid[k] = 1'b1;
        pc_instr[k] = seq[push_idx[k]].instr;
        pc_addr[k]  = seq[push_idx[k]].addr;
      end else begin
        pc_valid[k] = 1'b0;
        pc_instr[k] = $urandom;
        pc_addr[k]  = $urandom;
      end
    end
    dec_ready = (rdy_force >= 0) ? (rdy_force != 0) : (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  // One clock: sample handshakes/redirects at negedge, advance stimulus after posedge.
  task automatic tick();
    @(negedge clock);
    cycle_no++;
    for (int k = 0; k < 2; k++) begin
      acc[k] = pc_valid[k] && pc_ready[k];
      if (redir_valid[k] && red_n[k] < MAXN) begin
        obs_red[k][red_n[k]] = {(prev_pop[k] ? prev_addr[k] : 32'hFFFF_FFFF),
                                redir_kind[k], redir_eq[k], redir_port1[k]};
        red_n[k]++;
      end
      prev_pop[k]  = dec_valid[k] && dec_ready;
      prev_addr[k] = dec_addr[k];
      if (prev_pop[k] && iss_n[k] < MAXN) begin
        obs_iss[k][iss_n[k]] = {dec_instr[k], dec_addr[k]};
        obs_cyc[k][iss_n[k]] = cycle_no;
        iss_n[k]++;
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) if (acc[k]) push_idx[k]++;
    drive();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) pc_valid[k] = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic prep();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      iss_n[k] = 0; red_n[k] = 0; push_idx[k] = 0; prev_pop[k] = 1'b0;
    end
    drive();
  endtask

  task automatic run_seq(output bit done);
    int budget = 3000;
    while (budget > 0 && !(push_idx[0] >= seq_len && push_idx[1] >= seq_len)) begin
      tick();
      budget--;
    end
    rdy_force = 1;
    repeat (16) tick();
    done = (budget > 0);
  endtask

  function automatic logic [31:0] nop_at(input int i);
    return 32'h0000_0021 | (32'(i % 8) << 11);
  endfunction

  // Sequence-level reference: what issues, and which redirects are reported, for a given config.
  function automatic void build_exp(input int k, input int d, input int n);
    int skip = 0;
    bit slot = 1'b0;
    exp_iss_n[k] = 0;
    exp_red_n[k] = 0;
    for (int i = 0; i < seq_len; i++) begin
      logic [31:0] ins = seq[i].instr;
      int op = int'(ins[31:26]);
      int fn = int'(ins[5:0]);
      logic [31:0] a = regs[ins[25:21]];
      logic [31:0] b = regs[ins[20:16]];
      logic [1:0] kind = 2'd0;
      logic eq = 1'b0;
      logic [31:0] port1 = 32'd0;
      if (skip > 0) begin skip--; continue; end
      exp_iss[k][exp_iss_n[k]] = seq[i];
      exp_iss_n[k]++;
      if (slot) begin slot = 1'b0; skip = n; continue; end
      if (op == 4)      begin kind = 2'd1; eq = (a == b); end
      else if (op == 5) begin kind = 2'd1; eq = (a != b); end
      else if (op == 2 || op == 3) kind = 2'd2;
      else if (op == 0 && (fn == 8 || fn == 9)) begin kind = 2'd3; port1 = a; end
      if (kind != 2'd0) begin
        exp_red[k][exp_red_n[k]] = {seq[i].addr, kind, eq, port1};
        exp_red_n[k]++;
        if (kind != 2'd1 || eq) begin
          if (d != 0) slot = 1'b1;
          else skip = n;
        end
      end
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 31));
    logic [4:0] bs = 5'($urandom_range(0, 3));
    logic [4:0] bt = 5'($urandom_range(0, 3));
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {6'd0, rs, rt, rd, 5'd0, 6'h21};
      4:          return {6'd8, rs, rt, imm};
      5:          return {6'd4, bs, bt, imm};
      6:          return {6'd5, bs, bt, imm};
      7:          return {($urandom_range(0, 1) != 0) ? 6'd3 : 6'd2, 26'($urandom)};
      8:          return {6'd0, rs, 15'd0, ($urandom_range(0, 1) != 0) ? 6'd9 : 6'd8};
      default:    return {6'd35, rs, rt, imm};
    endcase
  endfunction

  task automatic test_reset();
    logic [100:0] got, want;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) pc_valid[k] = 1'b0;
    dec_ready = 1'b0;
    #3;
    want = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      got = {pc_ready[k], dec_valid[k], dec_instr[k], dec_addr[k],
             redir_valid[k], redir_kind[k], redir_port1[k], redir_eq[k]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_values dut%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_stream();
    bit done;
    seq_len = 3;
    for (int i = 0; i < 3; i++) seq[i] = {nop_at(i), 32'(4 * i)};
    valid_pct = 100; rdy_force = 1;
    prep();
    run_seq(done);
    for (int k = 0; k < 2; k++) build_exp(k, k == 0 ? D0 : D1, k == 0 ? N0 : N1);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL stream_timeout: got expired want done"); end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (iss_n[k] !== exp_iss_n[k] || red_n[k] !== 0) begin
        miscompares++;
        $display("FAIL stream_counts dut%0d: got %0d/%0d want %0d/0", k, iss_n[k], red_n[k], exp_iss_n[k]);
      end
      for (int i = 0; i < iss_n[k] && i < exp_iss_n[k]; i++) begin
        vectors++;
        if (obs_iss[k][i] !== exp_iss[k][i]) begin
          miscompares++;
          $display("FAIL stream_issue dut%0d #%0d: got %h want %h", k, i, obs_iss[k][i], exp_iss[k][i]);
        end
        if (i > 0) begin
          vectors++;
          if (obs_cyc[k][i] - obs_cyc[k][i-1] !== 1) begin
            miscompares++;
            $display("FAIL stream_rate dut%0d #%0d: got gap %0d want 1", k, i, obs_cyc[k][i] - obs_cyc[k][i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit done;
    seq_len = 5;
    for (int i = 0; i < 5; i++) seq[i] = {nop_at(i), 32'h80 + 32'(4 * i)};
    valid_pct = 100; rdy_force = 0;
    prep();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (push_idx[k] !== 2 || pc_ready[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_full dut%0d: got pushes %0d ready %b want 2 0", k, push_idx[k], pc_ready[k]);
      end
    end
    rdy_force = 1;
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pc_ready[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_pushpop_ready dut%0d: got %b want 1", k, pc_ready[k]);
      end
    end
    run_seq(done);
    for (int k = 0; k < 2; k++) build_exp(k, k == 0 ? D0 : D1, k == 0 ? N0 : N1);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL bp_timeout: got expired want done"); end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (iss_n[k] !== exp_iss_n[k]) begin
        miscompares++;
        $display("FAIL bp_count dut%0d: got %0d want %0d", k, iss_n[k], exp_iss_n[k]);
      end
      for (int i = 0; i < iss_n[k] && i < exp_iss_n[k]; i++) begin
        vectors++;
        if (obs_iss[k][i] !== exp_iss[k][i]) begin
          miscompares++;
          $display("FAIL bp_issue dut%0d #%0d: got %h want %h", k, i, obs_iss[k][i], exp_iss[k][i]);
        end
      end
    end
  endtask

  task automatic test_branches();
    bit done;
    logic [31:0] br   [3] = '{{6'd4, 5'd5, 5'd5, 16'h0003}, {6'd0, 5'd3, 15'd0, 6'd8}, {6'd5, 5'd5, 5'd5, 16'h0007}};
    logic [31:0] base [3] = '{32'h10, 32'h20, 32'h50};
    red_t want_red [3] = '{{32'h10, 2'd1, 1'b1, 32'h0}, {32'h20, 2'd3, 1'b0, 32'h100}, {32'h50, 2'd1, 1'b0, 32'h0}};
    int   want_n   [3][2] = '{'{3, 2}, '{4, 3}, '{4, 4}};
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[3] = 32'h100;
    for (int s = 0; s < 3; s++) begin
      seq_len = 4;
      seq[0] = {br[s], base[s]};
      for (int i = 1; i < 4; i++) seq[i] = {nop_at(i), base[s] + 32'(4 * i)};
      if (s == 0) seq[3].addr = 32'h40;
      if (s == 1) begin seq_len = 5; seq[4] = {nop_at(4), 32'h30}; end
      valid_pct = 100; rdy_force = 1;
      prep();
      run_seq(done);
      for (int k = 0; k < 2; k++) build_exp(k, k == 0 ? D0 : D1, k == 0 ? N0 : N1);
      vectors++;
      if (!done) begin miscompares++; $display("FAIL br_timeout s%0d: got expired want done", s); end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (red_n[k] !== 1 || obs_red[k][0] !== want_red[s]) begin
          miscompares++;
          $display("FAIL br_redirect s%0d dut%0d: got n=%0d %h want n=1 %h", s, k, red_n[k], obs_red[k][0], want_red[s]);
        end
        vectors++;
        if (iss_n[k] !== want_n[s][k] || exp_iss_n[k] !== want_n[s][k]) begin
          miscompares++;
          $display("FAIL br_issue_count s%0d dut%0d: got %0d want %0d", s, k, iss_n[k], want_n[s][k]);
        end
        for (int i = 0; i < iss_n[k] && i < exp_iss_n[k]; i++) begin
          vectors++;
          if (obs_iss[k][i] !== exp_iss[k][i]) begin
            miscompares++;
            $display("FAIL br_issue s%0d dut%0d #%0d: got %h want %h", s, k, i, obs_iss[k][i], exp_iss[k][i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    bit done;
    for (int it = 0; it < 10; it++) begin
      for (int r = 0; r < 32; r++) regs[r] = (r < 4) ? 32'($urandom_range(0, 1)) : $urandom;
      seq_len = 40;
      for (int i = 0; i < seq_len; i++) seq[i] = {rand_instr(), 32'h1000 * (it + 1) + 32'(4 * i)};
      valid_pct = int'($urandom_range(50, 100));
      rdy_pct   = int'($urandom_range(40, 100));
      rdy_force = -1;
      prep();
      run_seq(done);
      for (int k = 0; k < 2; k++) build_exp(k, k == 0 ? D0 : D1, k == 0 ? N0 : N1);
      vectors++;
      if (!done) begin miscompares++; $display("FAIL rand_timeout it%0d: got expired want done", it); end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (iss_n[k] !== exp_iss_n[k] || red_n[k] !== exp_red_n[k]) begin
          miscompares++;
          $display("FAIL rand_counts it%0d dut%0d: got %0d/%0d want %0d/%0d", it, k,
                   iss_n[k], red_n[k], exp_iss_n[k], exp_red_n[k]);
        end
        for (int i = 0; i < iss_n[k] && i < exp_iss_n[k]; i++) begin
          vectors++;
          if (obs_iss[k][i] !== exp_iss[k][i]) begin
            miscompares++;
            $display("FAIL rand_issue it%0d dut%0d #%0d: got %h want %h", it, k, i, obs_iss[k][i], exp_iss[k][i]);
          end
        end
        for (int i = 0; i < red_n[k] && i < exp_red_n[k]; i++) begin
          vectors++;
          if (obs_red[k][i] !== exp_red[k][i]) begin
            miscompares++;
            $display("FAIL rand_redirect it%0d dut%0d #%0d: got %h want %h", it, k, i, obs_red[k][i], exp_red[k][i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_in_squash();
    bit done;
    logic [100:0] got, want;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[3] = 32'h100;
    seq_len = 4;
    seq[0] = {{6'd0, 5'd3, 15'd0, 6'd8}, 32'h200};
    for (int i = 1; i < 4; i++) seq[i] = {nop_at(i), 32'h200 + 32'(4 * i)};
    valid_pct = 100; rdy_force = 0;
    prep();
    repeat (2) tick();
    rdy_force = 1;
    drive();
    tick();
    vectors++;
    if (dec_valid[1] !== 1'b0 || pc_ready[1] !== 1'b0 || redir_valid[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL squash_setup dut1: got valid %b ready %b redir %b want 0 0 1",
               dec_valid[1], pc_ready[1], redir_valid[1]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    want = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      got = {pc_ready[k], dec_valid[k], dec_instr[k], dec_addr[k],
             redir_valid[k], redir_kind[k], redir_port1[k], redir_eq[k]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL squash_reset dut%0d: got %h want %h", k, got, want);
      end
    end
    seq_len = 1;
    seq[0] = {nop_at(5), 32'h300};
    prep();
    run_seq(done);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL squash_timeout: got expired want done"); end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (iss_n[k] !== 1 || obs_iss[k][0] !== seq[0]) begin
        miscompares++;
        $display("FAIL squash_after_reset dut%0d: got n=%0d %h want n=1 %h", k, iss_n[k], obs_iss[k][0], seq[0]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    seq_len = 0;
    for (int k = 0; k < 2; k++) begin
      push_idx[k] = 0; iss_n[k] = 0; red_n[k] = 0;
      pc_instr[k] = 32'd0; pc_addr[k] = 32'd0;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_branches();
    test_random();
    test_reset_in_squash();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
